// File: rtl/metropolis_judge.sv
// metropolis_judge
//   Metropolis acceptance stage for one annealing replica. A positive distance
//   delta is negated, clamped and handed to the downstream combinational exp
//   unit; the returned exp(-delta*beta) is compared against an xorshift32
//   uniform draw to decide accept/reject. Non-positive deltas are always
//   accepted without consulting the exp unit.
//
//   Build option: define METROPOLIS_STAT_EN to implement the saturating
//   trial/accept counters; when undefined both stat outputs are tied to 0.
//
//   Ports
//     clk, reset        clock, asynchronous active-high reset
//     in_valid/in_ready delta handshake
//     delta             signed .17 distance change of the candidate move
//     exp_x             signed .17 argument to the exp unit
//     exp_y             signed .23 exp result (1.0 = 1<<23)
//     out_valid/ready   judgement handshake
//     out_accept        1 = accept move
//     stat_trials       completed trials (saturating)
//     stat_accepts      accepted trials (saturating)
//
//   state  | meaning
//   IDLE   | ready for a delta
//   CALC   | exp_x driven, exp_y sampled at end of cycle
//   RESULT | judgement presented until consumer takes it

module metropolis_judge #(
   parameter logic [31:0] SEED    = 32'h0000_0001,
   parameter int          SAT_NEG = -(1 << 20)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic signed [20:0] delta,
   output logic signed [20:0] exp_x,
   input  logic signed [26:0] exp_y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_accept,
   output logic [31:0]        stat_trials,
   output logic [31:0]        stat_accepts
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      RESULT = 2'd2
   } state_t;

   localparam logic [31:0]        SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic signed [21:0] SAT_NEG_W = SAT_NEG[21:0];
   localparam logic [31:0]        CNT_MAX   = 32'hFFFF_FFFF;

   function automatic logic [31:0] xs32(input logic [31:0] r);
      logic [31:0] t;
      t = r ^ (r << 13);
      t = t ^ (t >> 17);
      t = t ^ (t << 5);
      return t;
   endfunction

   state_t             state;
   state_t             state_nxt;
   logic [31:0]        rnd;
   logic               take;
   logic               ld_calc;
   logic               ld_imm;
   logic               ld_judge;
   logic               fire;
   logic               delta_nonpos;
   logic signed [21:0] neg_delta;
   logic signed [20:0] exp_x_sat;
   logic               exp_pos;
   logic               exp_full;
   logic               rnd_lt;
   logic               accept_calc;

   // One extra bit so negating the most-negative delta cannot overflow.
   assign neg_delta    = -{delta[20], delta};
   assign exp_x_sat    = (neg_delta < SAT_NEG_W) ? SAT_NEG_W[20:0] : neg_delta[20:0];
   assign delta_nonpos = delta[20] || (delta == 21'sd0);

   // exp_y <= 0 never accepts; exp_y >= 1.0 always accepts.
   assign exp_pos     = !exp_y[26] && (exp_y != 27'sd0);
   assign exp_full    = !exp_y[26] && (exp_y[25:23] != 3'd0);
   assign rnd_lt      = {1'b0, rnd[22:0]} < exp_y[23:0];
   assign accept_calc = (exp_pos && rnd_lt) || exp_full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      take      = 1'b0;
      ld_calc   = 1'b0;
      ld_imm    = 1'b0;
      ld_judge  = 1'b0;
      fire      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            take     = in_valid;
            if (take) begin
               if (delta_nonpos) begin
                  ld_imm    = 1'b1;
                  state_nxt = RESULT;
               end else begin
                  ld_calc   = 1'b1;
                  state_nxt = CALC;
               end
            end
         end
         CALC: begin
            ld_judge  = 1'b1;
            state_nxt = RESULT;
         end
         RESULT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               fire      = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_x      <= '0;
         out_accept <= 1'b0;
         rnd        <= SEED_EFF;
      end else begin
         if (ld_calc) begin
            exp_x <= exp_x_sat;
         end
         if (ld_imm) begin
            out_accept <= 1'b1;
         end else if (ld_judge) begin
            out_accept <= accept_calc;
         end
         // One draw per trial, consumed even by trials that skip the exp path.
         if (fire) begin
            rnd <= xs32(rnd);
         end
      end
   end

`ifdef METROPOLIS_STAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_trials  <= '0;
         stat_accepts <= '0;
      end else if (fire) begin
         if (stat_trials != CNT_MAX) begin
            stat_trials <= stat_trials + 32'd1;
         end
         if (out_accept && (stat_accepts != CNT_MAX)) begin
            stat_accepts <= stat_accepts + 32'd1;
         end
      end
   end
`else
   assign stat_trials  = '0;
   assign stat_accepts = '0;
`endif

endmodule

// File: tb/tb_metropolis_judge.sv
module tb_metropolis_judge;

   localparam logic [31:0] TB_SEED    = 32'h0000_0001;
   // Narrower than the delta range so the clamp is actually reachable.
   localparam int          TB_SAT_NEG = -(1 << 19);

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic signed [20:0] delta;
   logic signed [20:0] exp_x;
   logic signed [26:0] exp_y;
   logic               out_valid;
   logic               out_ready;
   logic               out_accept;
   logic [31:0]        stat_trials;
   logic [31:0]        stat_accepts;

   int n_pass  = 0;
   int n_total = 0;

   logic               exp_q[$];
   logic [31:0]        m_rnd;
   logic signed [20:0] m_exp_x;
   logic [31:0]        m_trials;
   logic [31:0]        m_accepts;

   metropolis_judge #(.SEED(TB_SEED), .SAT_NEG(TB_SAT_NEG)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .delta(delta), .exp_x(exp_x), .exp_y(exp_y), .out_valid(out_valid),
      .out_ready(out_ready), .out_accept(out_accept),
      .stat_trials(stat_trials), .stat_accepts(stat_accepts)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] m_step(input logic [31:0] r);
      logic [31:0] a;
      a = r ^ (r << 13);
      a = a ^ (a >> 17);
      a = a ^ (a << 5);
      return a;
   endfunction

   function automatic logic m_judge(input logic [31:0] r, input logic signed [26:0] ey);
      longint ey_l;
      longint u_l;
      ey_l = longint'(ey);
      u_l  = longint'(r[22:0]);
      if (ey_l >= 64'sd8388608) return 1'b1;
      if (ey_l <= 0) return 1'b0;
      return (u_l < ey_l);
   endfunction

   function automatic logic signed [20:0] m_sat(input logic signed [20:0] d);
      int v;
      v = -int'(d);
      if (v < TB_SAT_NEG) v = TB_SAT_NEG;
      return 21'(v);
   endfunction

   task automatic model_reset();
      m_rnd     = (TB_SEED == 32'd0) ? 32'd1 : TB_SEED;
      m_exp_x   = '0;
      m_trials  = '0;
      m_accepts = '0;
      exp_q.delete();
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   // Runs one complete trial starting from IDLE; hold = cycles out_ready stays low in RESULT.
   task automatic run_trial(input string name, input logic signed [20:0] d,
                            input logic signed [26:0] ey, input int hold);
      logic acc;
      int   lat;
      int   want_lat;
      exp_y = ey;
      if (d <= 0) begin
         exp_q.push_back(1'b1);
         want_lat = 1;
      end else begin
         m_exp_x = m_sat(d);
         exp_q.push_back(m_judge(m_rnd, ey));
         want_lat = 2;
      end
      @(negedge clk);
      in_valid = 1'b1;
      delta    = d;
      @(negedge clk);
      in_valid = 1'b0;
      delta    = 21'sh0AAAA;
      lat      = 1;
      if (d > 0) begin
         n_total++;
         if (in_ready !== 1'b0 || exp_x !== m_exp_x)
            $display("FAIL %s calc: in_ready=%b exp_x=%0d required in_ready=0 exp_x=%0d",
                     name, in_ready, exp_x, m_exp_x);
         else n_pass++;
      end
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      n_total++;
      if (lat !== want_lat)
         $display("FAIL %s latency: got %0d required %0d", name, lat, want_lat);
      else n_pass++;
      acc = exp_q.pop_front();
      n_total++;
      if (out_valid !== 1'b1 || out_accept !== acc || exp_x !== m_exp_x)
         $display("FAIL %s result: valid=%b accept=%b exp_x=%0d required valid=1 accept=%b exp_x=%0d",
                  name, out_valid, out_accept, exp_x, acc, m_exp_x);
      else n_pass++;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         n_total++;
         if (out_valid !== 1'b1 || out_accept !== acc || in_ready !== 1'b0)
            $display("FAIL %s hold%0d: valid=%b accept=%b in_ready=%b required 1 %b 0",
                     name, i, out_valid, out_accept, in_ready, acc);
         else n_pass++;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL %s release: valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
      else n_pass++;
      m_rnd = m_step(m_rnd);
      m_trials++;
      if (acc) m_accepts++;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      delta     = '0;
      exp_y     = '0;
      repeat (3) @(negedge clk);
      n_total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_accept !== 1'b0 || exp_x !== 21'sd0 ||
          stat_trials !== 32'd0 || stat_accepts !== 32'd0)
         $display("FAIL reset_values: in_ready=%b out_valid=%b accept=%b exp_x=%0d trials=%0d accepts=%0d required 1 0 0 0 0 0",
                  in_ready, out_valid, out_accept, exp_x, stat_trials, stat_accepts);
      else n_pass++;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_neg_delta();
      run_trial("neg_delta", -21'sh100, 27'sd0, 0);
      run_trial("zero_delta", 21'sd0, -27'sd7, 0);
   endtask

   task automatic test_pos_delta();
      apply_reset();
      run_trial("pos_first", 21'sh20000, 27'sh000002, 0);
      run_trial("strict_lt", 21'sh20000, 27'sh042021, 0);
      apply_reset();
      run_trial("dummy", -21'sd1, 27'sd0, 0);
      run_trial("just_above", 21'sh20000, 27'sh042022, 0);
   endtask

   task automatic test_saturation();
      run_trial("sat_zero", 21'sh0FFFFF, 27'sd0, 0);
      run_trial("sat_negy", 21'sh0FFFFF, -27'sd5, 0);
      run_trial("below_sat", 21'sh07FFFF, 27'sh800000, 0);
      run_trial("at_sat", 21'sh080000, 27'sh3FFFFFF, 0);
      run_trial("mid", 21'sh01234, 27'sh400000, 0);
   endtask

   task automatic test_hold();
      run_trial("hold", 21'sh20000, 27'sh400000, 10);
      run_trial("after_hold", 21'sh00400, 27'sh400000, 0);
   endtask

   task automatic test_back_to_back();
      int   lat;
      logic acc;
      run_trial("b2b_a", 21'sh00800, 27'sh200000, 0);
      exp_y = 27'sh300000;
      @(negedge clk);
      in_valid = 1'b1;
      delta    = -21'sd5;
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b1 || out_accept !== 1'b1)
         $display("FAIL b2b_first: valid=%b accept=%b required 1 1", out_valid, out_accept);
      else n_pass++;
      // out_ready and a new delta together: the delta must wait one cycle.
      out_ready = 1'b1;
      delta     = 21'sh00100;
      m_rnd     = m_step(m_rnd);
      m_trials++;
      m_accepts++;
      acc       = m_judge(m_rnd, exp_y);
      exp_q.push_back(acc);
      @(negedge clk);
      out_ready = 1'b0;
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL b2b_wait: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      else n_pass++;
      @(negedge clk);
      in_valid = 1'b0;
      m_exp_x  = m_sat(21'sh00100);
      lat      = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      acc = exp_q.pop_front();
      n_total++;
      if (lat !== 2 || out_accept !== acc || exp_x !== m_exp_x)
         $display("FAIL b2b_second: lat=%0d accept=%b exp_x=%0d required 2 %b %0d",
                  lat, out_accept, exp_x, acc, m_exp_x);
      else n_pass++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      m_rnd = m_step(m_rnd);
      m_trials++;
      if (acc) m_accepts++;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      run_trial("pre_abort", -21'sd3, 27'sd0, 0);
      exp_y = 27'sd2;
      @(negedge clk);
      in_valid = 1'b1;
      delta    = 21'sh20000;
      @(negedge clk);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      n_total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || exp_x !== 21'sd0)
         $display("FAIL reset_mid: valid=%b in_ready=%b exp_x=%0d required 0 1 0",
                  out_valid, in_ready, exp_x);
      else n_pass++;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      // Seed value 1 is below 2, anything advanced past it is not.
      run_trial("seed_again", 21'sh20000, 27'sd2, 0);
   endtask

   task automatic test_stats();
      logic [31:0] want_t;
      logic [31:0] want_a;
      apply_reset();
      run_trial("st1", -21'sd10, 27'sd0, 0);
      run_trial("st2", 21'sh00010, 27'sd0, 0);
      run_trial("st3", 21'sh00010, 27'sh800000, 0);
      run_trial("st4", 21'sd0, 27'sd0, 0);
      run_trial("st5", 21'sh00020, -27'sd1, 0);
`ifdef METROPOLIS_STAT_EN
      want_t = m_trials;
      want_a = m_accepts;
`else
      want_t = 32'd0;
      want_a = 32'd0;
`endif
      n_total++;
      if (stat_trials !== want_t || stat_accepts !== want_a)
         $display("FAIL stats: trials=%0d accepts=%0d required %0d %0d",
                  stat_trials, stat_accepts, want_t, want_a);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_neg_delta();
      test_pos_delta();
      test_saturation();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      test_stats();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
